// File: rtl/uart_tx_frame.sv
// UART transmit framer: start bit, LSB-first data, optional parity, stop.
// One serial bit per clock; TX_OUT and Busy are registered outputs.
module uart_tx_frame #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] P_DATA,
  input  logic             Data_Valid,
  input  logic             PAR_EN,
  input  logic             PAR_TYP,
  output logic             TX_OUT,
  output logic             Busy
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  logic [2:0]       state;
  logic [2:0]       state_n;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_n;
  logic [WIDTH-1:0] data_q;
  logic             pen_q;
  logic             ptyp_q;
  logic             accept;
  logic             par_bit;
  logic             tx_n;
  logic             busy_n;

  assign accept  = (state == IDLE) && Data_Valid;
  assign par_bit = (^data_q) ^ ptyp_q;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      IDLE: begin
        if (Data_Valid) state_n = START;
      end
      START: begin
        state_n = DATA;
        cnt_n   = '0;
      end
      DATA: begin
        if (cnt == CW'(WIDTH - 1)) begin
          state_n = pen_q ? PARITY : STOP;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      PARITY: state_n = STOP;
      STOP:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they leave the flops
  // in step with the state register.
  always_comb begin
    tx_n   = 1'b1;
    busy_n = (state_n != IDLE);
    unique case (state_n)
      START:  tx_n = 1'b0;
      DATA:   tx_n = data_q[cnt_n];
      PARITY: tx_n = par_bit;
      default: tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state  <= IDLE;
      cnt    <= '0;
      data_q <= '0;
      pen_q  <= 1'b0;
      ptyp_q <= 1'b0;
      TX_OUT <= 1'b1;
      Busy   <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      TX_OUT <= tx_n;
      Busy   <= busy_n;
      if (accept) begin
        data_q <= P_DATA;
        pen_q  <= PAR_EN;
        ptyp_q <= PAR_TYP;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: per-cycle {Busy,TX_OUT} scoreboard
// filled when a request is driven, drained one entry per clock.
module tb_uart_tx_frame;

  localparam int WIDTH = 8;

  logic             CLK;
  logic             RST;
  logic [WIDTH-1:0] P_DATA;
  logic             Data_Valid;
  logic             PAR_EN;
  logic             PAR_TYP;
  logic             TX_OUT;
  logic             Busy;

  logic [1:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  uart_tx_frame #(.WIDTH(WIDTH)) dut (
    .CLK(CLK),
    .RST(RST),
    .P_DATA(P_DATA),
    .Data_Valid(Data_Valid),
    .PAR_EN(PAR_EN),
    .PAR_TYP(PAR_TYP),
    .TX_OUT(TX_OUT),
    .Busy(Busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%b exp=%b t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Expected line per cycle for one frame, parity from a bit count.
  task automatic push_frame(input logic [WIDTH-1:0] d,
                            input logic pen, input logic ptyp);
    int ones;
    logic pb;
    ones = 0;
    exp_q.push_back(2'b10);
    for (int i = 0; i < WIDTH; i++) begin
      exp_q.push_back({1'b1, d[i]});
      if (d[i]) ones++;
    end
    if (pen) begin
      pb = (ones % 2 == 1);
      if (ptyp) pb = !pb;
      exp_q.push_back({1'b1, pb});
    end
    exp_q.push_back(2'b11);
  endtask

  task automatic cycle(input string tag);
    logic [1:0] e;
    @(posedge CLK);
    #1;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else e = 2'b01;
    chk({tag, "_busy"}, Busy, e[1]);
    chk({tag, "_tx"}, TX_OUT, e[0]);
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) cycle(tag);
  endtask

  task automatic send(input string tag, input logic [WIDTH-1:0] d,
                      input logic pen, input logic ptyp);
    P_DATA     = d;
    PAR_EN     = pen;
    PAR_TYP    = ptyp;
    Data_Valid = 1'b1;
    push_frame(d, pen, ptyp);
    cycle(tag);
    Data_Valid = 1'b0;
    run(tag, exp_q.size() + 2);
  endtask

  initial begin
    RST        = 1'b1;
    P_DATA     = '0;
    Data_Valid = 1'b0;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;

    // asynchronous reset before any clock edge
    #2 RST = 1'b0;
    #1;
    chk("rst_tx", TX_OUT, 1'b1);
    chk("rst_busy", Busy, 1'b0);
    run("rst_hold", 2);
    RST = 1'b1;
    run("rst_idle", 3);

    send("even_a5", 8'hA5, 1'b1, 1'b0);
    send("odd_07", 8'h07, 1'b1, 1'b1);
    send("odd_03", 8'h03, 1'b1, 1'b1);

    // back-to-back, Data_Valid held: frame, one idle cycle, frame
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;
    P_DATA     = 8'hFF;
    Data_Valid = 1'b1;
    push_frame(8'hFF, 1'b0, 1'b0);
    exp_q.push_back(2'b01);
    push_frame(8'h00, 1'b0, 1'b0);
    cycle("b2b");
    P_DATA = 8'h00;
    run("b2b", 11);
    Data_Valid = 1'b0;
    run("b2b", exp_q.size() + 2);

    // inputs disturbed while the frame is in flight
    P_DATA     = 8'h3C;
    PAR_EN     = 1'b1;
    PAR_TYP    = 1'b0;
    Data_Valid = 1'b1;
    push_frame(8'h3C, 1'b1, 1'b0);
    cycle("ign");
    Data_Valid = 1'b0;
    cycle("ign");
    P_DATA     = 8'hC3;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b1;
    for (int i = 0; i < 6; i++) begin
      Data_Valid = ~Data_Valid;
      cycle("ign");
    end
    Data_Valid = 1'b0;
    run("ign", exp_q.size() + 3);

    // reset during the 4th data bit
    P_DATA     = 8'h96;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;
    Data_Valid = 1'b1;
    push_frame(8'h96, 1'b0, 1'b0);
    cycle("abort");
    Data_Valid = 1'b0;
    run("abort", 4);
    #2 RST = 1'b0;
    #1;
    chk("abort_tx", TX_OUT, 1'b1);
    chk("abort_busy", Busy, 1'b0);
    exp_q.delete();
    run("abort_hold", 2);
    RST = 1'b1;
    cycle("abort_idle");
    send("post_55", 8'h55, 1'b1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

UART transmit framer: accepts a parallel word and serialises it on one line, one bit per clock. The frame is a start bit, the data LSB first, an optional parity bit, then one stop bit. It is the transmit-side counterpart of the receive path's parity checker. It uses the same parity convention, so a frame from this block produces no parity error at the receiver when both sides use the same PAR_EN and PAR_TYP. CLK runs at the baud rate; baud generation sits upstream.

## Interface
- WIDTH, 8, data word width (≥ 2)
- CLK  input  1  bit clock, one serial bit per rising edge
- RST  input  1  asynchronous, active-low reset
- P_DATA  input  WIDTH  parallel word to send
- Data_Valid  input  1  request; P_DATA is valid this cycle
- PAR_EN  input  1  1 = insert parity bit
- PAR_TYP  input  1  0 = even parity, 1 = odd parity
- TX_OUT  output  1  serial line, idles high
- Busy  output  1  frame in progress; requests are ignored while high

## Operation
- FSM states are IDLE, START, DATA, PARITY, STOP. The encoding is free.
- **Accept.** A request is taken on a rising edge where state = IDLE and Data_Valid = 1.
  - On that edge, P_DATA, PAR_EN and PAR_TYP are latched into internal registers.
  - The next state is START.
  - Input changes after acceptance do not affect the frame in flight.
- **Parity.** It is computed from the latched word.
  - Even (PAR_TYP = 0): parity bit = ^data.
  - Odd (PAR_TYP = 1): parity bit = ~^data.
- **State outputs.**
  - IDLE: TX_OUT = 1, Busy = 0.
  - START: TX_OUT = 0, Busy = 1. Next state is DATA; the bit counter clears to 0.
  - DATA: TX_OUT = data[cnt], Busy = 1. The counter is ceil(log2(WIDTH)) bits wide.
    - When cnt = WIDTH-1, the next state is PARITY if the latched PAR_EN = 1, else STOP.
    - Otherwise cnt increments.
  - PARITY: TX_OUT = parity bit, Busy = 1. Next state is STOP.
  - STOP: TX_OUT = 1, Busy = 1. Next state is IDLE unconditionally.
- **Ignored requests.** Data_Valid outside IDLE is ignored. It is not queued, and there is no error flag.
- **Output quality.** TX_OUT and Busy come straight from flops: no combinational path from any input, and no glitches.

## Timing
- **Reset values.** While RST = 0: TX_OUT = 1, Busy = 0, state = IDLE, counter = 0.
  - Reset takes effect immediately, without waiting for a clock.
- **Reset mid-frame.** The frame is aborted and the line returns high immediately. The first cycle after release is IDLE.
- **Latency.** The start bit appears on TX_OUT in the cycle after the accepting edge.
- **Frame length.** Busy is high for WIDTH+2 cycles without parity, or WIDTH+3 with parity.
  - For WIDTH = 8 that is 10 or 11 cycles.
- **Minimum gap between frames.** After STOP, at least one IDLE cycle with TX_OUT = 1.
  - A Data_Valid held high continuously is accepted on the edge that ends that IDLE cycle.
  - Frame period is therefore WIDTH+3 cycles without parity, WIDTH+4 with parity.
- **Simultaneous events.** Data_Valid asserted in the same cycle STOP ends is not accepted. It must still be high in the following IDLE cycle.

## Test plan
- **Reset.** Assert RST low mid-cycle with no clock edge.
  - Required: TX_OUT = 1 and Busy = 0 immediately. After release, idle line, Busy = 0.
- **Even parity.** P_DATA = 8'hA5, PAR_EN = 1, PAR_TYP = 0, one-cycle Data_Valid.
  - Required TX_OUT sequence, starting the cycle after acceptance: 0,1,0,1,0,0,1,0,1,0,1 (parity 0).
  - Busy is high for exactly 11 cycles, then low.
- **Odd parity.** P_DATA = 8'h07, PAR_EN = 1, PAR_TYP = 1.
  - Required sequence: 0,1,1,1,0,0,0,0,0,0,1 (parity 0, since ^data = 1 and the bit is inverted).
  - Repeat with P_DATA = 8'h03: parity bit = 1.
- **No parity, back-to-back.** PAR_EN = 0, P_DATA = 8'hFF then 8'h00, Data_Valid held high throughout.
  - Frame 1 is 10 bits, followed by exactly one idle-high cycle, then frame 2's start bit.
  - Frame 2 data bits are all 0, and Busy dips low for exactly one cycle between frames.
- **Inputs ignored mid-frame.** After accepting 8'h3C, change P_DATA to 8'hC3 and toggle PAR_EN, PAR_TYP and Data_Valid during DATA.
  - Required: the serial output still matches 8'h3C with the originally latched parity settings.
  - No second frame starts until after STOP and one IDLE cycle.
- **Reset abort.** Assert RST during the 4th data bit.
  - Required: TX_OUT = 1 and Busy = 0 at once.
  - After release, a new request for 8'h55 produces a complete, correct frame.
